spi_slave: RTL
==============

Name: spi_slave

Overview:
SPI Mode 0 (CPOL=0, CPHA=0) target that answers the team's SPI master.
- sclk, cs_n and mosi are asynchronous inputs; the block synchronises them into the clk domain and detects edges there.
- Full-duplex, MSB first, DATA_W bits per word, back-to-back words allowed within one cs_n assertion.
- Parallel side is a one-entry TX buffer (valid/ready) and an RX word output with a 1-cycle valid pulse.

Parameters:
DATA_W, 8, word width in bits (>=2)
SYNC_STAGES, 2, flip-flop stages per synchroniser on sclk/cs_n/mosi (>=2)

Ports:
clk  in  1  system clock; must be >= 8x the sclk frequency
rst  in  1  synchronous, active-high reset
sclk  in  1  SPI clock from master (asynchronous)
cs_n  in  1  chip select, active low (asynchronous)
mosi  in  1  master-out data (asynchronous)
miso  out  1  slave-out data
miso_oe  out  1  output enable for the miso pad; high only while selected
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  TX buffer empty; transfer happens when tx_valid && tx_ready
rx_data  out  DATA_W  last completely received word; held until the next word
rx_valid  out  1  1-cycle pulse when rx_data updates
tx_underrun  out  1  1-cycle pulse: a word started with an empty TX buffer
busy  out  1  high while in ACTIVE

Behaviour:
- Reset: all outputs low except tx_ready=1. rx_data=0, miso=0, miso_oe=0, busy=0. Synchronisers preset to sclk=0, cs_n=1, mosi=0. TX buffer empty, state IDLE.
- Synchronisers: SYNC_STAGES flops per input. Edges are detected by comparing the last synchronised stage with a one-flop delayed copy. All three inputs share the same latency, so the relative timing of mosi and sclk is preserved.
- TX buffer: one entry.
  - Loads on tx_valid && tx_ready; tx_ready drops the next cycle.
  - Emptied when a word is loaded into the shift register; tx_ready returns the next cycle.
  - A load and a consume in the same cycle: consume the old entry and store the new one; tx_ready stays 0.
- State IDLE:
  - miso_oe=0, miso=0.
  - On a synchronised cs_n falling edge: go to ACTIVE, set miso_oe=1, bit_cnt=0.
  - Load tx_shift from the buffer, or all zeros plus a tx_underrun pulse if the buffer is empty.
  - miso = tx_shift MSB in the same cycle.
- State ACTIVE:
  - sclk rising edge: rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}, then bit_cnt++.
    - If bit_cnt was DATA_W-1: rx_data <= the completed word and rx_valid pulses the next cycle.
    - Set word_done, and bit_cnt wraps to 0.
  - sclk falling edge, word_done clear: tx_shift shifts left, miso = the new MSB.
  - sclk falling edge, word_done set: clear word_done and reload tx_shift from the buffer (underrun rule as above); miso = the new MSB.
  - cs_n rising edge (any time): return to IDLE, miso_oe=0, clear bit_cnt and word_done.
    - A partial word is discarded with no rx_valid.
    - An unconsumed TX buffer entry is retained.
  - cs_n rising and sclk edge in the same cycle: cs_n wins, the sclk edge is ignored.
- Timing requirements on the master (documented constraint, not checked in RTL):
  - Delay from cs_n fall to the first sclk rise >= SYNC_STAGES+3 clk cycles.
  - sclk high and low phases each >= SYNC_STAGES+1 clk cycles.
- Latency: rx_valid asserts SYNC_STAGES+2 clk cycles after the final sclk rising edge at the pin.
- rst mid-transfer: immediate return to reset values. After rst deasserts, a transfer in progress (cs_n still low) is ignored until cs_n next rises and falls, because the synchroniser preset (cs_n=1) makes the block see a fresh falling edge.
  - Required behaviour: track an armed flag that is cleared by rst and set by synchronised cs_n=1; ACTIVE may only be entered while armed.

Decomposition:
- Package spi_pkg: state enum (IDLE, ACTIVE), default DATA_W, SPI mode constant shared with the master.
- Sub-module spi_sync_edge: parameterised N-stage synchroniser with reset preset value, plus rise/fall pulse outputs. Instantiated three times (mosi uses only the level output).

Test Plan:
- Single exchange: preload tx 0x3C; master sends 0xA5 -> master receives 0x3C, rx_data=0xA5, one rx_valid pulse, no underrun.
- Back-to-back in one cs_n: tx 0x11 then, on tx_ready, 0x22; master sends 0xF0, 0x0F -> miso yields 0x11, 0x22; rx_valid twice with 0xF0, 0x0F; tx_ready rises after each consume.
- Underrun: no tx_valid; master sends 0x5A -> tx_underrun pulses at cs_n fall, miso=0x00 throughout, rx_data=0x5A.
- Abort: cs_n rises after 3 sclk cycles of 0xC3 -> no rx_valid, rx_data unchanged; the next full transfer of 0x81 gives rx_data=0x81.
- Reset mid-transfer: rst for 2 cycles after bit 4 while cs_n stays low -> all outputs at reset values; the remaining bits are ignored; a subsequent cs_n cycle transfers 0x7E correctly.
- Minimum timing: sclk phases at exactly SYNC_STAGES+1 clk cycles, random words x100 -> all words match in both directions.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, default word width and the bus mode
// agreed with the team's SPI master.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam int DEFAULT_DATA_W = 8;

    // Mode 0: CPOL=0, CPHA=0 (sample on rising sclk, shift on falling sclk).
    localparam logic [1:0] SPI_MODE = 2'd0;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous input, with a reset preset value
// and single-cycle rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic PRESET = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{PRESET}};
            dly_q  <= PRESET;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~dly_q;
    assign fall_o  = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 target: oversamples sclk/cs_n/mosi in the clk domain, full-duplex
// MSB-first words, one-entry TX buffer and a pulsed RX word output.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_rise, cs_fall, cs_lvl;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .PRESET(1'b0)) u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .d_i     (sclk),
        .level_o (sclk_lvl_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .d_i     (cs_n),
        .level_o (cs_lvl),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .PRESET(1'b0)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .d_i     (mosi),
        .level_o (mosi_lvl),
        .rise_o  (mosi_rise_unused),
        .fall_o  (mosi_fall_unused)
    );

    spi_state_e          state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                word_done_q, word_done_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-2:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                underrun_q, underrun_d;
    logic                miso_q, miso_d;
    logic                miso_oe_q, miso_oe_d;
    logic [DATA_W-1:0]   tx_buf_q, tx_buf_d;
    logic                tx_full_q, tx_full_d;
    logic                armed_q, armed_d;
    logic [FILL_W-1:0]   fill_q, fill_d;

    logic                reload;
    logic                tx_consume;
    logic                tx_load;
    logic                fill_done;
    logic [DATA_W-1:0]   rx_word;

    // The synchroniser preset reads as cs_n=1 right after reset; only a
    // cs_n=1 observed once the pipeline holds real pin samples arms the FSM,
    // so a transfer already in progress at reset release is ignored.
    assign fill_done = (fill_q == FILL_MAX);
    assign fill_d    = fill_done ? fill_q : fill_q + FILL_W'(1);
    assign armed_d   = armed_q | (fill_done & cs_lvl);

    assign rx_word = {rx_shift_q, mosi_lvl};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = word_done_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        miso_oe_d   = miso_oe_q;
        reload      = 1'b0;
        tx_consume  = 1'b0;

        case (state_q)
            IDLE: begin
                miso_oe_d = 1'b0;
                if (cs_fall && armed_q) begin
                    state_d     = ACTIVE;
                    miso_oe_d   = 1'b1;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    reload      = 1'b1;
                end
            end
            ACTIVE: begin
                // Deselect has priority over any coincident sclk edge.
                if (cs_rise) begin
                    state_d     = IDLE;
                    miso_oe_d   = 1'b0;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_word[DATA_W-2:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d   = rx_word;
                        rx_valid_d  = 1'b1;
                        word_done_d = 1'b1;
                        bit_cnt_d   = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    if (word_done_q) begin
                        word_done_d = 1'b0;
                        reload      = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (reload) begin
            if (tx_full_q) begin
                tx_shift_d = tx_buf_q;
                tx_consume = 1'b1;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end

        miso_d = (state_d == ACTIVE) ? tx_shift_d[DATA_W-1] : 1'b0;
    end

    assign tx_load   = tx_valid & ~tx_full_q;
    assign tx_full_d = tx_load | (tx_full_q & ~tx_consume);
    assign tx_buf_d  = tx_load ? tx_data : tx_buf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            armed_q     <= 1'b0;
            fill_q      <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            armed_q     <= armed_d;
            fill_q      <= fill_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = ~tx_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign busy        = (state_q == ACTIVE);

endmodule
